// File: rtl/sha256_uart_tx.sv
// sha256_uart_tx: captures a digest in one handshake and sends it as NUM_BYTES UART frames,
// most-significant byte first, LSB-first within a byte. Define SHA_TX_TWO_STOP_EN for 8N2 framing.
module sha256_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] digest_in,
  input  logic                   digest_valid,
  output logic                   digest_ready,
  output logic                   data_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int DW = 8 * NUM_BYTES;
`ifdef SHA_TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            data_out_q, data_out_d;
  logic            done_q, done_d;
  logic            baud_last_s;
  logic [7:0]      cur_byte_s;

  assign baud_last_s  = (baud_q == BAUD_LAST);
  assign digest_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign data_out     = data_out_q;
  assign done         = done_q;

  // State, counters, shift register and registered line/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_q     <= '0;
      shreg_q    <= '0;
      data_out_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; bit_q also counts stop-bit periods in the two-stop build.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (digest_valid) begin
          shreg_d = digest_in;
          byte_d  = '0;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_last_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_q < STOP_LAST) begin
            bit_d = bit_q + 3'd1;
          end else if (byte_q < BYTE_LAST) begin
            bit_d   = 3'd0;
            shreg_d = shreg_q << 8;
            byte_d  = byte_q + BW'(1);
            state_d = START;
          end else begin
            bit_d   = 3'd0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level decoded from the next state so data_out changes on the same edge as the state.
  always_comb begin
    cur_byte_s = shreg_d[DW-1 -: 8];
    data_out_d = 1'b1;
    case (state_d)
      IDLE:    data_out_d = 1'b1;
      START:   data_out_d = 1'b0;
      DATA:    data_out_d = cur_byte_s[bit_d];
      STOP:    data_out_d = 1'b1;
      default: data_out_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sha256_uart_tx.sv
// Self-checking bench for sha256_uart_tx: scoreboard of expected bytes popped by a mid-bit UART receiver.
`timescale 1ns/1ps
module tb_sha256_uart_tx;

  localparam int C  = 4;
  localparam int NB = 32;
`ifdef SHA_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam int FRAME      = (9 + STOP_BITS) * C;
  localparam int DIGEST_CYC = NB * FRAME;
  localparam logic [255:0] GOLDEN =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [8*NB-1:0] digest_in = '0;
  logic            digest_valid = 1'b0;
  logic            digest_ready, data_out, busy, done;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int          ready_viol = 0;
  logic        watch_busy = 1'b0;
  int          fall_cyc = 0;
  logic [7:0]  exp_q[$];

  sha256_uart_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .digest_in(digest_in), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  always @(negedge clk) if (watch_busy && digest_ready !== 1'b0) ready_viol <= ready_viol + 1;

  task automatic push_bytes(input logic [8*NB-1:0] d);
    for (int i = 0; i < NB; i++) exp_q.push_back(d[8*NB-1-8*i -: 8]);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_digest(input logic [8*NB-1:0] d, output int acc);
    checks++;
    if (digest_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got=%b want=1", digest_ready);
    end
    digest_in = d;
    digest_valid = 1'b1;
    push_bytes(d);
    @(negedge clk);
    acc = cyc;
    digest_valid = 1'b0;
    digest_in = ~d;
  endtask

  task automatic recv_byte(input string tag);
    int n;
    logic [7:0] b, e;
    n = 0;
    while (data_out !== 1'b0 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (data_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_timeout got=%b want=0", tag, data_out);
      return;
    end
    fall_cyc = cyc;
    repeat (C / 2) @(negedge clk);
    checks++;
    if (data_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_mid got=%b want=0", tag, data_out);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = data_out;
    end
    repeat (C) @(negedge clk);
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL %s_stop got=%b want=1", tag, data_out);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_byte got=%h want=none", tag, b);
    end else begin
      e = exp_q.pop_front();
      if (b !== e) begin
        errors++;
        $display("FAIL %s_byte got=%h want=%h", tag, b, e);
      end
    end
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2 * DIGEST_CYC) begin
      @(negedge clk);
      n++;
    end
    dcyc = cyc;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got=%b want=1", tag, done);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({data_out, digest_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=1100", {data_out, digest_ready, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, digest_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=1100", {data_out, digest_ready, busy, done});
    end
  endtask

  task automatic test_golden();
    int acc, first_fall, dcyc, dc0;
    dc0 = done_cnt;
    send_digest(GOLDEN, acc);
    for (int i = 0; i < NB; i++) begin
      recv_byte("golden");
      if (i == 0) first_fall = fall_cyc;
    end
    checks++;
    if (first_fall != acc) begin
      errors++;
      $display("FAIL golden_start_latency got=%0d want=%0d", first_fall, acc);
    end
    wait_done("golden", dcyc);
    checks++;
    if (dcyc - first_fall != DIGEST_CYC) begin
      errors++;
      $display("FAIL golden_total_cycles got=%0d want=%0d", dcyc - first_fall, DIGEST_CYC);
    end
    checks++;
    if (digest_ready !== 1'b1) begin
      errors++;
      $display("FAIL golden_ready_on_done got=%b want=1", digest_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL golden_done_width got=%b want=0", done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - dc0 != 1) begin
      errors++;
      $display("FAIL golden_done_count got=%0d want=1", done_cnt - dc0);
    end
  endtask

  task automatic test_bit_timing();
    int acc, ntr, last, bad, gap;
    logic prev, seen_done;
    send_digest({NB{8'h55}}, acc);
    exp_q.delete();
    prev = 1'b1; ntr = 0; last = 0; bad = 0; seen_done = 1'b0;
    for (int n = 0; n < 2 * DIGEST_CYC && !seen_done; n++) begin
      if (data_out !== prev) begin
        if (ntr == 0) begin
          checks++;
          if (cyc != acc) begin
            errors++;
            $display("FAIL timing_first_fall got=%0d want=%0d", cyc, acc);
          end
        end else begin
          gap = ((ntr - 1) % 10 == 9) ? STOP_BITS * C : C;
          if (cyc - last != gap) bad++;
        end
        last = cyc;
        prev = data_out;
        ntr++;
      end
      if (done === 1'b1) seen_done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timing_gaps got=%0d_bad want=0", bad);
    end
    checks++;
    if (ntr != NB * 10 || !seen_done) begin
      errors++;
      $display("FAIL timing_transitions got=%0d done=%b want=%0d done=1", ntr, seen_done, NB * 10);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_protect();
    logic [8*NB-1:0] a, b;
    int dcyc;
    a = GOLDEN;
    b = ~GOLDEN ^ {NB{8'h3c}};
    digest_in = a;
    digest_valid = 1'b1;
    push_bytes(a);
    @(negedge clk);
    digest_in = b;
    watch_busy = 1'b1;
    for (int i = 0; i < NB; i++) recv_byte("busy_a");
    watch_busy = 1'b0;
    wait_done("busy_a", dcyc);
    checks++;
    if (digest_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_ready_on_done got=%b want=1", digest_ready);
    end
    push_bytes(b);
    @(negedge clk);
    digest_valid = 1'b0;
    checks++;
    if (data_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_restart got=%b%b want=01", data_out, busy);
    end
    checks++;
    if (ready_viol != 0) begin
      errors++;
      $display("FAIL busy_ready_low got=%0d_cycles_high want=0", ready_viol);
    end
    for (int i = 0; i < NB; i++) recv_byte("busy_b");
    wait_done("busy_b", dcyc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [8*NB-1:0] d2;
    int acc, dcyc, lows;
    send_digest(GOLDEN, acc);
    for (int i = 0; i < 5; i++) recv_byte("rst_pre");
    repeat (STOP_BITS * C + 3 * C) @(negedge clk);
    checks++;
    if (data_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_frame got=%b%b want=01", data_out, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, busy, digest_ready} !== 3'b101) begin
      errors++;
      $display("FAIL rst_async got=%b want=101", {data_out, busy, digest_ready});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL rst_no_resume got=%0d_active_cycles want=0", lows);
    end
    for (int i = 0; i < NB; i++) d2[8*NB-1-8*i -: 8] = 8'(i * 37 + 11);
    send_digest(d2, acc);
    for (int i = 0; i < NB; i++) recv_byte("rst_post");
    wait_done("rst_post", dcyc);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_bit_timing();
    test_busy_protect();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
